// File: rtl/mul_acc_unit.sv
// Iterative multiply / multiply-accumulate engine for the EX stage.
// Retires STEP_BITS multiplier bits per cycle on operand magnitudes, then fixes sign and accumulates.
module mul_acc_unit #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned STEP_BITS = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic                 annul_i,
  input  logic                 signed_i,
  input  logic [1:0]           op_i,
  input  logic [WIDTH-1:0]     opdata1_i,
  input  logic [WIDTH-1:0]     opdata2_i,
  input  logic [WIDTH-1:0]     hi_i,
  input  logic [WIDTH-1:0]     lo_i,
  output logic [2*WIDTH-1:0]   result_o,
  output logic                 ready_o,
  output logic                 busy_o
);

  localparam int unsigned N    = WIDTH / STEP_BITS;
  localparam int unsigned CntW = $clog2(N + 1);
  localparam int unsigned PW   = 2 * WIDTH;

  typedef enum logic [1:0] {StIdle, StOn, StFix, StEnd} state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   mcand_q, mcand_d;
  logic [PW-1:0]   prod_q, prod_d;
  logic [PW-1:0]   base_q, base_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            neg_q, neg_d;
  logic [1:0]      op_q, op_d;

  logic [WIDTH-1:0] mag1, mag2;
  logic [PW-1:0]    partial, signed_prod;

  // Magnitude of the most-negative value wraps to itself, which is correct as unsigned.
  always_comb begin
    mag1        = (signed_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
    mag2        = (signed_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
    partial     = mcand_q * PW'(mplier_q[STEP_BITS-1:0]);
    signed_prod = neg_q ? -prod_q : prod_q;
  end

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    prod_d   = prod_q;
    base_d   = base_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    op_d     = op_q;
    unique case (state_q)
      StIdle: begin
        if (start_i && !annul_i) begin
          state_d  = StOn;
          mcand_d  = PW'(mag1);
          mplier_d = mag2;
          neg_d    = signed_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
          op_d     = op_i;
          base_d   = {hi_i, lo_i};
          prod_d   = '0;
          cnt_d    = '0;
        end
      end
      StOn: begin
        if (annul_i) begin
          state_d = StIdle;
        end else begin
          // Multiplicand pre-shifted so each partial product lands in place.
          prod_d   = prod_q + partial;
          mcand_d  = mcand_q << STEP_BITS;
          mplier_d = mplier_q >> STEP_BITS;
          cnt_d    = cnt_q + CntW'(1);
          if (cnt_q == CntW'(N - 1)) state_d = StFix;
        end
      end
      StFix: begin
        if (annul_i) begin
          state_d = StIdle;
        end else begin
          case (op_q)
            2'b01:   prod_d = base_q + signed_prod;
            2'b10:   prod_d = base_q - signed_prod;
            default: prod_d = signed_prod;
          endcase
          state_d = StEnd;
        end
      end
      StEnd: begin
        if (!start_i || annul_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      mcand_q  <= '0;
      prod_q   <= '0;
      base_q   <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      op_q     <= 2'b00;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      prod_q   <= prod_d;
      base_q   <= base_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      op_q     <= op_d;
    end
  end

  assign ready_o  = (state_q == StEnd);
  assign busy_o   = (state_q == StOn) || (state_q == StFix);
  assign result_o = ready_o ? prod_q : '0;

endmodule

// File: tb/tb_mul_acc_unit.sv
// Self-checking bench for mul_acc_unit: directed cases on the 32/2 build plus a
// random sweep over several (WIDTH, STEP_BITS) builds sharing one stimulus.
module tb_mul_acc_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, annul, sgn;
  logic [1:0]  op;
  logic [31:0] a, b, hi, lo;

  logic [63:0] r0, r1, r2, r3;
  logic [31:0] r4;
  logic [4:0]  rdy, bsy;

  int errs = 0;
  int checks = 0;
  int lat [5];
  logic [63:0] got [5];
  bit busy_err;
  int wid [5] = '{32, 32, 32, 32, 16};
  int stp [5] = '{2, 1, 4, 8, 2};

  always #5 clk = ~clk;

  mul_acc_unit #(.WIDTH(32), .STEP_BITS(2)) u_main (
    .clk(clk), .rst(rst), .start_i(start), .annul_i(annul), .signed_i(sgn), .op_i(op),
    .opdata1_i(a), .opdata2_i(b), .hi_i(hi), .lo_i(lo),
    .result_o(r0), .ready_o(rdy[0]), .busy_o(bsy[0])
  );
  mul_acc_unit #(.WIDTH(32), .STEP_BITS(1)) u_s1 (
    .clk(clk), .rst(rst), .start_i(start), .annul_i(annul), .signed_i(sgn), .op_i(op),
    .opdata1_i(a), .opdata2_i(b), .hi_i(hi), .lo_i(lo),
    .result_o(r1), .ready_o(rdy[1]), .busy_o(bsy[1])
  );
  mul_acc_unit #(.WIDTH(32), .STEP_BITS(4)) u_s4 (
    .clk(clk), .rst(rst), .start_i(start), .annul_i(annul), .signed_i(sgn), .op_i(op),
    .opdata1_i(a), .opdata2_i(b), .hi_i(hi), .lo_i(lo),
    .result_o(r2), .ready_o(rdy[2]), .busy_o(bsy[2])
  );
  mul_acc_unit #(.WIDTH(32), .STEP_BITS(8)) u_s8 (
    .clk(clk), .rst(rst), .start_i(start), .annul_i(annul), .signed_i(sgn), .op_i(op),
    .opdata1_i(a), .opdata2_i(b), .hi_i(hi), .lo_i(lo),
    .result_o(r3), .ready_o(rdy[3]), .busy_o(bsy[3])
  );
  mul_acc_unit #(.WIDTH(16), .STEP_BITS(2)) u_w16 (
    .clk(clk), .rst(rst), .start_i(start), .annul_i(annul), .signed_i(sgn), .op_i(op),
    .opdata1_i(a[15:0]), .opdata2_i(b[15:0]), .hi_i(hi[15:0]), .lo_i(lo[15:0]),
    .result_o(r4), .ready_o(rdy[4]), .busy_o(bsy[4])
  );

  function automatic logic [63:0] res_of(int i);
    case (i)
      0: return r0;
      1: return r1;
      2: return r2;
      3: return r3;
      default: return {32'h0, r4};
    endcase
  endfunction

  // Reference: true product of the (sign-extended) operands, then accumulate, mod 2^(2w).
  function automatic logic [63:0] model(int w, bit sg, logic [1:0] o, logic [31:0] x,
                                         logic [31:0] y, logic [31:0] h, logic [31:0] l);
    logic [63:0] xe, ye, p, base, r, mask;
    if (w == 32) begin
      xe   = sg ? {{32{x[31]}}, x} : {32'h0, x};
      ye   = sg ? {{32{y[31]}}, y} : {32'h0, y};
      base = {h, l};
      mask = '1;
    end else begin
      xe   = sg ? {{48{x[15]}}, x[15:0]} : {48'h0, x[15:0]};
      ye   = sg ? {{48{y[15]}}, y[15:0]} : {48'h0, y[15:0]};
      base = {32'h0, h[15:0], l[15:0]};
      mask = 64'h0000_0000_FFFF_FFFF;
    end
    p = xe * ye;
    case (o)
      2'b01:   r = base + p;
      2'b10:   r = base - p;
      default: r = p;
    endcase
    return r & mask;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'h8000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h0;
      3: return 32'h0000_8000;
      default: return $urandom;
    endcase
  endfunction

  // Drives one request and holds start until every build reports ready (or timeout).
  task automatic run_op(bit sg, logic [1:0] o, logic [31:0] x, logic [31:0] y,
                        logic [31:0] h, logic [31:0] l);
    bit all_done;
    sgn = sg; op = o; a = x; b = y; hi = h; lo = l;
    start = 1'b1; annul = 1'b0;
    busy_err = 1'b0;
    for (int i = 0; i < 5; i++) begin
      lat[i] = -1;
      got[i] = 'x;
    end
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin
        // Post-accept input changes must not matter.
        a = $urandom; b = $urandom; hi = $urandom; lo = $urandom;
        sgn = 1'($urandom); op = 2'($urandom);
      end
      all_done = 1'b1;
      for (int i = 0; i < 5; i++) begin
        if (lat[i] < 0) begin
          if (rdy[i]) begin
            lat[i] = k - 1;
            got[i] = res_of(i);
            if (bsy[i]) busy_err = 1'b1;
          end else begin
            if (!bsy[i]) busy_err = 1'b1;
            all_done = 1'b0;
          end
        end
      end
      if (all_done) break;
    end
  endtask

  task automatic drop_start();
    start = 1'b0; annul = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; annul = 1'b0; sgn = 1'b0; op = 2'b00;
    a = '0; b = '0; hi = '0; lo = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (rdy !== 5'b0) begin errs++; $display("FAIL reset_ready got=%b exp=00000", rdy); end
    checks++; if (bsy !== 5'b0) begin errs++; $display("FAIL reset_busy got=%b exp=00000", bsy); end
    checks++; if (r0 !== 64'h0) begin errs++; $display("FAIL reset_result got=%h exp=0", r0); end
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_unsigned_max();
    run_op(1'b0, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0);
    checks++; if (got[0] !== 64'hFFFF_FFFE_0000_0001) begin
      errs++; $display("FAIL umax_result got=%h exp=fffffffe00000001", got[0]);
    end
    checks++; if (lat[0] != 17) begin errs++; $display("FAIL umax_latency got=%0d exp=17", lat[0]); end
    checks++; if (busy_err) begin errs++; $display("FAIL umax_busy got=bad exp=high_until_ready"); end
    drop_start();
  endtask

  task automatic test_signed();
    run_op(1'b1, 2'b00, 32'hFFFF_FFFD, 32'd7, 32'h0, 32'h0);
    checks++; if (got[0] !== 64'hFFFF_FFFF_FFFF_FFEB) begin
      errs++; $display("FAIL signed_m3x7 got=%h exp=ffffffffffffffeb", got[0]);
    end
    drop_start();
    run_op(1'b1, 2'b00, 32'h8000_0000, 32'h8000_0000, 32'h0, 32'h0);
    checks++; if (got[0] !== 64'h4000_0000_0000_0000) begin
      errs++; $display("FAIL signed_minmin got=%h exp=4000000000000000", got[0]);
    end
    drop_start();
  endtask

  task automatic test_accumulate();
    run_op(1'b1, 2'b01, 32'd4, 32'd5, 32'h0, 32'h10);
    checks++; if (got[0] !== 64'h0000_0000_0000_0024) begin
      errs++; $display("FAIL madd got=%h exp=0000000000000024", got[0]);
    end
    drop_start();
    run_op(1'b0, 2'b10, 32'd1, 32'd1, 32'h0, 32'h0);
    checks++; if (got[0] !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      errs++; $display("FAIL msubu_wrap got=%h exp=ffffffffffffffff", got[0]);
    end
    drop_start();
  endtask

  task automatic test_annul();
    bit seen;
    sgn = 1'b0; op = 2'b00; a = 32'h1234_5678; b = 32'h9ABC_DEF0; hi = '0; lo = '0;
    start = 1'b1; annul = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checks++; if (bsy[0] !== 1'b1) begin errs++; $display("FAIL annul_prebusy got=%b exp=1", bsy[0]); end
    annul = 1'b1; start = 1'b0;
    @(posedge clk); #1;
    annul = 1'b0;
    checks++; if (bsy[0] !== 1'b0) begin errs++; $display("FAIL annul_busy got=%b exp=0", bsy[0]); end
    seen = 1'b0;
    repeat (25) begin
      @(posedge clk); #1;
      if (rdy[0]) seen = 1'b1;
    end
    checks++; if (seen) begin errs++; $display("FAIL annul_ready got=1 exp=0"); end
    run_op(1'b0, 2'b00, 32'd1000, 32'd3000, 32'h0, 32'h0);
    checks++; if (got[0] !== 64'd3000000) begin
      errs++; $display("FAIL after_annul_result got=%h exp=%h", got[0], 64'd3000000);
    end
    checks++; if (lat[0] != 17) begin errs++; $display("FAIL after_annul_latency got=%0d exp=17", lat[0]); end
    drop_start();
  endtask

  task automatic test_reset_mid();
    sgn = 1'b1; op = 2'b01; a = 32'hDEAD_BEEF; b = 32'h0BAD_F00D; hi = 32'h1; lo = 32'h2;
    start = 1'b1; annul = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    checks++; if (bsy[0] !== 1'b0 || rdy[0] !== 1'b0 || r0 !== 64'h0) begin
      errs++; $display("FAIL reset_mid got=busy%b ready%b res%h exp=all0", bsy[0], rdy[0], r0);
    end
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    run_op(1'b1, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0);
    checks++; if (got[0] !== 64'h1) begin errs++; $display("FAIL after_reset_result got=%h exp=1", got[0]); end
    drop_start();
  endtask

  task automatic test_hold();
    logic [63:0] exp;
    exp = model(32, 1'b0, 2'b00, 32'h0001_0001, 32'h0002_0003, 32'h0, 32'h0);
    run_op(1'b0, 2'b00, 32'h0001_0001, 32'h0002_0003, 32'h0, 32'h0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      checks++; if (rdy[0] !== 1'b1 || r0 !== exp) begin
        errs++; $display("FAIL hold_stable got=ready%b res%h exp=ready1 res%h", rdy[0], r0, exp);
      end
    end
    start = 1'b0;
    @(posedge clk); #1;
    checks++; if (rdy[0] !== 1'b0 || r0 !== 64'h0) begin
      errs++; $display("FAIL hold_release got=ready%b res%h exp=ready0 res0", rdy[0], r0);
    end
  endtask

  task automatic test_start_annul_idle();
    sgn = 1'b0; op = 2'b00; a = 32'd5; b = 32'd6;
    start = 1'b1; annul = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      checks++; if (bsy[0] !== 1'b0 || rdy[0] !== 1'b0) begin
        errs++; $display("FAIL start_annul_idle got=busy%b ready%b exp=0 0", bsy[0], rdy[0]);
      end
    end
    drop_start();
  endtask

  task automatic test_sweep();
    bit sg;
    logic [1:0] o;
    logic [31:0] x, y, h, l;
    logic [63:0] exp;
    for (int t = 0; t < 30; t++) begin
      sg = 1'($urandom); o = 2'($urandom);
      x = pick(); y = pick(); h = $urandom; l = $urandom;
      run_op(sg, o, x, y, h, l);
      for (int i = 0; i < 5; i++) begin
        exp = model(wid[i], sg, o, x, y, h, l);
        checks++; if (got[i] !== exp) begin
          errs++; $display("FAIL sweep_result w%0d s%0d t%0d got=%h exp=%h", wid[i], stp[i], t,
                           got[i], exp);
        end
        checks++; if (lat[i] != wid[i] / stp[i] + 1) begin
          errs++; $display("FAIL sweep_latency w%0d s%0d got=%0d exp=%0d", wid[i], stp[i], lat[i],
                           wid[i] / stp[i] + 1);
        end
      end
      checks++; if (busy_err) begin errs++; $display("FAIL sweep_busy t%0d got=bad exp=ok", t); end
      drop_start();
      checks++; if (rdy !== 5'b0) begin errs++; $display("FAIL sweep_idle got=%b exp=00000", rdy); end
    end
  endtask

  initial begin
    test_reset();
    test_unsigned_max();
    test_signed();
    test_accumulate();
    test_annul();
    test_reset_mid();
    test_hold();
    test_start_annul_idle();
    test_sweep();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
